// File: rtl/softmax_approx_pkg.sv
// Shared widths, limits and types for the softmax approximation pipeline stages.
package softmax_approx_pkg;

  localparam int LOG_W    = 16;
  localparam int LOG_FRAC = 10;
  localparam int LIN_W    = 32;
  localparam int LIN_FRAC = 10;

  // Largest left shift whose {1,f} mantissa still fits the linear word.
  localparam int POW2_MAX_LSHIFT = LIN_W - LOG_FRAC - 1;
  // Right shift at which even the all-ones mantissa drops below one LSB.
  localparam int POW2_UF_SHIFT   = LIN_FRAC + 1;

  localparam int MANT_W  = LOG_FRAC + 1;
  localparam int SHAMT_W = 5;

  typedef logic signed [LOG_W-1:0] q6_10_t;
  typedef logic [LIN_W-1:0]        lin_t;

  typedef enum logic [1:0] {
    CLS_LEFT,
    CLS_RIGHT,
    CLS_SAT,
    CLS_UF
  } pow2_cls_e;

endpackage

// File: rtl/pow2_barrel_shift.sv
// Combinational mantissa shifter for the antilog stage; POW2_ROUND_EN selects
// round-half-up on right shifts instead of truncation.
module pow2_barrel_shift
  import softmax_approx_pkg::*;
(
  input  logic [MANT_W-1:0]  m,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               dir_right,
  input  pow2_cls_e          cls,
  output lin_t               result
);

  lin_t m_ext;
  lin_t left_res;
  lin_t right_res;

  assign m_ext    = {{(LIN_W - MANT_W){1'b0}}, m};
  assign left_res = m_ext << shamt;

`ifdef POW2_ROUND_EN
  logic [MANT_W:0] rnd_sum;

  // Right shifts are always 1..10 here, so shamt-1 never underflows in use.
  assign rnd_sum   = {1'b0, m} + ((MANT_W + 1)'(1) << (shamt - SHAMT_W'(1)));
  assign right_res = {{(LIN_W - MANT_W - 1){1'b0}}, rnd_sum >> shamt};
`else
  assign right_res = m_ext >> shamt;
`endif

  always_comb begin
    result = '0;
    case (cls)
      CLS_SAT: result = '1;
      CLS_UF:  result = '0;
      default: result = dir_right ? right_res : left_res;
    endcase
  end

endmodule

// File: rtl/stage3_pow2_approx.sv
// Three-stage Mitchell antilog 2^x on a signed Q6.10 input with stall, bypass lanes and a
// saturating clip counter. Define POW2_ROUND_EN for round-half-up right shifts.
module stage3_pow2_approx
  import softmax_approx_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_clr_cnt,
  input  logic             i_valid,
  input  logic [LOG_W-1:0] i_log2_in0,
  input  logic [15:0]      i_in1,
  output logic             o_valid,
  output logic [LIN_W-1:0] o_pow2,
  output logic             o_sat,
  output logic             o_uf,
  output logic [15:0]      o_in1_byp,
  output logic [LOG_W-1:0] o_log2_byp,
  output logic [CNT_W-1:0] o_clip_cnt
);

  logic         s0_valid;
  q6_10_t       s0_x;
  logic [15:0]  s0_in1;

  logic               s1_valid;
  q6_10_t             s1_x;
  logic [15:0]        s1_in1;
  logic [MANT_W-1:0]  s1_m;
  logic [SHAMT_W-1:0] s1_shamt;
  logic               s1_right;
  pow2_cls_e          s1_cls;

  int                 int_part;
  logic [MANT_W-1:0]  dec_m;
  logic [SHAMT_W-1:0] dec_shamt;
  logic               dec_right;
  pow2_cls_e          dec_cls;

  lin_t shift_res;
  logic s1_clip;
  logic clip_inc;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s0_valid <= 1'b0;
      s0_x     <= '0;
      s0_in1   <= '0;
    end else if (i_en) begin
      s0_valid <= i_valid;
      s0_x     <= i_log2_in0;
      s0_in1   <= i_in1;
    end
  end

  always_comb begin
    int_part  = {{(32 - (LOG_W - LOG_FRAC)){s0_x[LOG_W-1]}}, s0_x[LOG_W-1:LOG_FRAC]};
    dec_m     = {1'b1, s0_x[LOG_FRAC-1:0]};
    dec_shamt = '0;
    dec_right = 1'b0;
    dec_cls   = CLS_LEFT;
    if (int_part > POW2_MAX_LSHIFT) begin
      dec_cls = CLS_SAT;
    end else if (int_part >= 0) begin
      dec_shamt = SHAMT_W'(int_part);
    end else if (int_part > -POW2_UF_SHIFT) begin
      dec_cls   = CLS_RIGHT;
      dec_right = 1'b1;
      dec_shamt = SHAMT_W'(-int_part);
    end else begin
      dec_cls = CLS_UF;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid <= 1'b0;
      s1_x     <= '0;
      s1_in1   <= '0;
      s1_m     <= '0;
      s1_shamt <= '0;
      s1_right <= 1'b0;
      s1_cls   <= CLS_LEFT;
    end else if (i_en) begin
      s1_valid <= s0_valid;
      s1_x     <= s0_x;
      s1_in1   <= s0_in1;
      s1_m     <= dec_m;
      s1_shamt <= dec_shamt;
      s1_right <= dec_right;
      s1_cls   <= dec_cls;
    end
  end

  pow2_barrel_shift u_shift (
    .m         (s1_m),
    .shamt     (s1_shamt),
    .dir_right (s1_right),
    .cls       (s1_cls),
    .result    (shift_res)
  );

  assign s1_clip  = (s1_cls == CLS_SAT) || (s1_cls == CLS_UF);
  assign clip_inc = i_en && s1_valid && s1_clip;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid    <= 1'b0;
      o_pow2     <= '0;
      o_sat      <= 1'b0;
      o_uf       <= 1'b0;
      o_in1_byp  <= '0;
      o_log2_byp <= '0;
    end else if (i_en) begin
      o_valid    <= s1_valid;
      o_pow2     <= shift_res;
      o_sat      <= s1_valid && (s1_cls == CLS_SAT);
      o_uf       <= s1_valid && (s1_cls == CLS_UF);
      o_in1_byp  <= s1_in1;
      o_log2_byp <= s1_x;
    end
  end

  // Clear beats a same-edge increment; the count sticks at all-ones.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_clip_cnt <= '0;
    end else if (i_clr_cnt) begin
      o_clip_cnt <= '0;
    end else if (clip_inc && (o_clip_cnt != '1)) begin
      o_clip_cnt <= o_clip_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_stage3_pow2_approx.sv
// Directed self-checking bench for stage3_pow2_approx (small counter width to reach saturation).
module tb_stage3_pow2_approx;

  localparam int CNT_W = 4;

  logic             i_clk = 1'b0;
  logic             i_rst;
  logic             i_en;
  logic             i_clr_cnt;
  logic             i_valid;
  logic [15:0]      i_log2_in0;
  logic [15:0]      i_in1;
  logic             o_valid;
  logic [31:0]      o_pow2;
  logic             o_sat;
  logic             o_uf;
  logic [15:0]      o_in1_byp;
  logic [15:0]      o_log2_byp;
  logic [CNT_W-1:0] o_clip_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int cnt_exp = 0;

`ifdef POW2_ROUND_EN
  localparam logic [31:0] DbffExp = 32'h0000_0002;
`else
  localparam logic [31:0] DbffExp = 32'h0000_0001;
`endif

  logic [15:0] vec_x [7] = '{16'h0000, 16'h0600, 16'hFC00, 16'h57FF, 16'h5800, 16'h8000, 16'hDBFF};
  logic [31:0] vec_y [7] = '{32'h0000_0400, 32'h0000_0C00, 32'h0000_0200, 32'hFFE0_0000,
                             32'hFFFF_FFFF, 32'h0000_0000, DbffExp};
  logic        vec_s [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic        vec_u [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  logic [15:0] bx [5] = '{16'h0400, 16'h0800, 16'hF800, 16'h0A00, 16'h1000};
  logic [31:0] by [5] = '{32'h0000_0800, 32'h0000_1000, 32'h0000_0100, 32'h0000_1800,
                          32'h0000_4000};

  stage3_pow2_approx #(.CNT_W(CNT_W)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_en       (i_en),
    .i_clr_cnt  (i_clr_cnt),
    .i_valid    (i_valid),
    .i_log2_in0 (i_log2_in0),
    .i_in1      (i_in1),
    .o_valid    (o_valid),
    .o_pow2     (o_pow2),
    .o_sat      (o_sat),
    .o_uf       (o_uf),
    .o_in1_byp  (o_in1_byp),
    .o_log2_byp (o_log2_byp),
    .o_clip_cnt (o_clip_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset;
    i_rst = 1'b1; i_en = 1'b1; i_clr_cnt = 1'b0; i_valid = 1'b0;
    i_log2_in0 = '0; i_in1 = '0;
    tick();
    tick();
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL reset o_valid: got %b want 0", o_valid); end
    n_cmp++; if (o_pow2 !== 32'h0) begin n_err++; $display("FAIL reset o_pow2: got %h want 0", o_pow2); end
    n_cmp++; if ({o_sat, o_uf} !== 2'b00) begin n_err++; $display("FAIL reset sat/uf: got %b want 00", {o_sat, o_uf}); end
    n_cmp++; if (o_in1_byp !== 16'h0) begin n_err++; $display("FAIL reset o_in1_byp: got %h want 0", o_in1_byp); end
    n_cmp++; if (o_log2_byp !== 16'h0) begin n_err++; $display("FAIL reset o_log2_byp: got %h want 0", o_log2_byp); end
    n_cmp++; if (o_clip_cnt !== '0) begin n_err++; $display("FAIL reset o_clip_cnt: got %0d want 0", o_clip_cnt); end
    i_rst = 1'b0;
  endtask

  task automatic test_vectors;
    for (int k = 0; k < 7; k++) begin
      i_valid = 1'b1; i_log2_in0 = vec_x[k]; i_in1 = 16'hA000 + 16'(k);
      tick();
      i_valid = 1'b0; i_log2_in0 = '0; i_in1 = '0;
      tick();
      tick();
      if (vec_s[k] || vec_u[k]) cnt_exp++;
      n_cmp++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL vec%0d o_valid: got %b want 1", k, o_valid); end
      n_cmp++; if (o_pow2 !== vec_y[k]) begin n_err++; $display("FAIL vec%0d o_pow2: got %h want %h", k, o_pow2, vec_y[k]); end
      n_cmp++; if (o_sat !== vec_s[k]) begin n_err++; $display("FAIL vec%0d o_sat: got %b want %b", k, o_sat, vec_s[k]); end
      n_cmp++; if (o_uf !== vec_u[k]) begin n_err++; $display("FAIL vec%0d o_uf: got %b want %b", k, o_uf, vec_u[k]); end
      n_cmp++; if (o_in1_byp !== 16'hA000 + 16'(k)) begin n_err++; $display("FAIL vec%0d o_in1_byp: got %h want %h", k, o_in1_byp, 16'hA000 + 16'(k)); end
      n_cmp++; if (o_log2_byp !== vec_x[k]) begin n_err++; $display("FAIL vec%0d o_log2_byp: got %h want %h", k, o_log2_byp, vec_x[k]); end
      n_cmp++; if (int'(o_clip_cnt) !== cnt_exp) begin n_err++; $display("FAIL vec%0d o_clip_cnt: got %0d want %0d", k, o_clip_cnt, cnt_exp); end
    end
  endtask

  task automatic test_invalid_clip;
    i_valid = 1'b0; i_log2_in0 = 16'h5800; i_in1 = 16'h5555;
    for (int c = 0; c < 4; c++) tick();
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL inv_clip o_valid: got %b want 0", o_valid); end
    n_cmp++; if (o_sat !== 1'b0) begin n_err++; $display("FAIL inv_clip o_sat: got %b want 0", o_sat); end
    n_cmp++; if (o_pow2 !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL inv_clip o_pow2: got %h want ffffffff", o_pow2); end
    n_cmp++; if (int'(o_clip_cnt) !== cnt_exp) begin n_err++; $display("FAIL inv_clip o_clip_cnt: got %0d want %0d", o_clip_cnt, cnt_exp); end
  endtask

  task automatic test_back_to_back;
    int idx = 0;
    int e = 0;
    int k;
    for (int cyc = 0; cyc < 10; cyc++) begin
      i_en = !(cyc == 3 || cyc == 4);
      if (idx < 5) begin
        i_valid = 1'b1; i_log2_in0 = bx[idx]; i_in1 = 16'hB000 + 16'(idx);
      end else begin
        i_valid = 1'b0; i_log2_in0 = '0; i_in1 = '0;
      end
      tick();
      if (i_en) begin idx++; e++; end
      if (e >= 3) begin
        k = e - 3;
        if (k < 5) begin
          n_cmp++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL b2b cyc%0d o_valid: got %b want 1", cyc, o_valid); end
          n_cmp++; if (o_pow2 !== by[k]) begin n_err++; $display("FAIL b2b cyc%0d o_pow2: got %h want %h", cyc, o_pow2, by[k]); end
          n_cmp++; if (o_in1_byp !== 16'hB000 + 16'(k)) begin n_err++; $display("FAIL b2b cyc%0d o_in1_byp: got %h want %h", cyc, o_in1_byp, 16'hB000 + 16'(k)); end
          n_cmp++; if (o_log2_byp !== bx[k]) begin n_err++; $display("FAIL b2b cyc%0d o_log2_byp: got %h want %h", cyc, o_log2_byp, bx[k]); end
        end else begin
          n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL b2b cyc%0d o_valid: got %b want 0", cyc, o_valid); end
        end
      end
    end
    i_en = 1'b1;
  endtask

  task automatic test_counter;
    i_clr_cnt = 1'b1;
    tick();
    i_clr_cnt = 1'b0;
    cnt_exp = 0;
    n_cmp++; if (o_clip_cnt !== '0) begin n_err++; $display("FAIL cnt_clear o_clip_cnt: got %0d want 0", o_clip_cnt); end
    i_valid = 1'b1; i_log2_in0 = 16'h8000;
    for (int c = 0; c < 18; c++) tick();
    i_valid = 1'b0; i_log2_in0 = '0;
    for (int c = 0; c < 3; c++) tick();
    cnt_exp = 15;
    n_cmp++; if (int'(o_clip_cnt) !== cnt_exp) begin n_err++; $display("FAIL cnt_sat o_clip_cnt: got %0d want %0d", o_clip_cnt, cnt_exp); end
    i_valid = 1'b1; i_log2_in0 = 16'h8000;
    tick();
    i_valid = 1'b0; i_log2_in0 = '0;
    tick();
    i_clr_cnt = 1'b1;
    tick();
    i_clr_cnt = 1'b0;
    cnt_exp = 0;
    n_cmp++; if ({o_valid, o_uf} !== 2'b11) begin n_err++; $display("FAIL cnt_clr_evt valid/uf: got %b want 11", {o_valid, o_uf}); end
    n_cmp++; if (int'(o_clip_cnt) !== cnt_exp) begin n_err++; $display("FAIL cnt_clr_evt o_clip_cnt: got %0d want 0", o_clip_cnt); end
  endtask

  task automatic test_reset_midstream;
    i_valid = 1'b1; i_log2_in0 = 16'h5800; i_in1 = 16'hC0DE;
    for (int c = 0; c < 3; c++) tick();
    n_cmp++; if ({o_valid, o_sat} !== 2'b11) begin n_err++; $display("FAIL rst_mid pre valid/sat: got %b want 11", {o_valid, o_sat}); end
    i_rst = 1'b1;
    tick();
    n_cmp++; if ({o_valid, o_sat, o_uf} !== 3'b000) begin n_err++; $display("FAIL rst_mid flags: got %b want 000", {o_valid, o_sat, o_uf}); end
    n_cmp++; if (o_pow2 !== 32'h0) begin n_err++; $display("FAIL rst_mid o_pow2: got %h want 0", o_pow2); end
    n_cmp++; if ({o_in1_byp, o_log2_byp} !== 32'h0) begin n_err++; $display("FAIL rst_mid bypass: got %h want 0", {o_in1_byp, o_log2_byp}); end
    n_cmp++; if (o_clip_cnt !== '0) begin n_err++; $display("FAIL rst_mid o_clip_cnt: got %0d want 0", o_clip_cnt); end
    i_rst = 1'b0; i_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid stale%0d o_valid: got %b want 0", c, o_valid); end
    end
    i_valid = 1'b1; i_log2_in0 = 16'h0000; i_in1 = 16'h1234;
    tick();
    i_valid = 1'b0;
    tick();
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid early o_valid: got %b want 0", o_valid); end
    tick();
    n_cmp++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL rst_mid new o_valid: got %b want 1", o_valid); end
    n_cmp++; if (o_pow2 !== 32'h0000_0400) begin n_err++; $display("FAIL rst_mid new o_pow2: got %h want 00000400", o_pow2); end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_invalid_clip();
    test_back_to_back();
    test_counter();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
